// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants for the instruction-fetch stage:
//   - phase encoding of the two-state FETCH/EXEC sequencer
//   - default widths for the program counter, ROM word and fetch counter
//   - split position of a ROM word into opcode (upper half) / operand (lower half)
// -----------------------------------------------------------------------------
package fetch_pkg;

    // One bit is enough for the two phases, so no illegal encodings exist.
    localparam logic [0:0] PHASE_FETCH = 1'b0;
    localparam logic [0:0] PHASE_EXEC  = 1'b1;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    // Width of the operand field. The operand sits in bits [w-1:0] and the
    // opcode in bits [data_w-1:w]. data_w is expected to be even.
    function automatic int oprnd_width(input int data_w);
        return data_w / 2;
    endfunction

endpackage : fetch_pkg

// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// Loadable, incrementing program counter with asynchronous active-high reset.
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high; clears pc to 0
//   enable     in   pc changes only while 1
//   inc        in   advance pc by one (wraps from all-ones to 0)
//   load       in   replace pc with load_addr; wins over inc
//   load_addr  in   jump target
//   pc         out  current program counter
// -----------------------------------------------------------------------------
module program_counter
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        // NOTE: the hold value is assigned first so every path drives pc_d and
        // no latch is inferred.
        pc_d = pc_q;
        if (enable) begin
            if (load) begin
                pc_d = load_addr;
            end else if (inc) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values,
    // independent of the order in which always blocks are evaluated.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule : program_counter

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage in front of the accumulator/ALU datapath. Each
// instruction takes two clocks: FETCH latches the ROM word and bumps pc,
// EXEC lets the downstream datapath act and optionally takes a jump.
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high; clears all state
//   run          in   stage advances only while 1, otherwise everything holds
//   load_pc      in   jump request, honoured only in EXEC
//   load_addr    in   jump target
//   rom_data     in   combinational ROM read data at address pc
//   pc           out  program counter / ROM address
//   instr        out  latched opcode   (upper half of the ROM word)
//   oprnd        out  latched operand  (lower half of the ROM word)
//   phase        out  0 = FETCH, 1 = EXEC
//   fetch_count  out  instructions fetched since reset, saturating
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  load_pc,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic [ADDR_W-1:0]     pc,
    output logic [DATA_W/2-1:0]   instr,
    output logic [DATA_W/2-1:0]   oprnd,
    output logic                  phase,
    output logic [CNT_W-1:0]      fetch_count
);

    localparam int OPRND_W = oprnd_width(DATA_W);

    logic [0:0]         phase_q, phase_d;
    logic [OPRND_W-1:0] instr_q, instr_d;
    logic [OPRND_W-1:0] oprnd_q, oprnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic in_fetch;
    assign in_fetch = (phase_q == PHASE_FETCH);

    // pc increments on the fetch edge; a jump is only accepted on the exec edge,
    // so load_pc during FETCH cannot disturb the increment.
    program_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clock     (clock),
        .reset     (reset),
        .enable    (run),
        .inc       (in_fetch),
        .load      (!in_fetch && load_pc),
        .load_addr (load_addr),
        .pc        (pc)
    );

    always_comb begin
        phase_d = phase_q;
        instr_d = instr_q;
        oprnd_d = oprnd_q;
        cnt_d   = cnt_q;
        if (run) begin
            if (in_fetch) begin
                instr_d = rom_data[DATA_W-1:OPRND_W];
                oprnd_d = rom_data[OPRND_W-1:0];
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                phase_d = PHASE_EXEC;
            end else begin
                phase_d = PHASE_FETCH;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q <= PHASE_FETCH;
            instr_q <= '0;
            oprnd_q <= '0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            instr_q <= instr_d;
            oprnd_q <= oprnd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr       = instr_q;
    assign oprnd       = oprnd_q;
    assign phase       = phase_q[0];
    assign fetch_count = cnt_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A behavioural model (ROM array, integer
// program counter and fetch tally) tracks the architectural state and every
// scenario compares the DUT against it and against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              run;
    logic              load_pc;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] rom_data;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        instr;
    logic [3:0]        oprnd;
    logic              phase;
    logic [CNT_W-1:0]  fetch_count;

    logic [7:0] rom [0:4095];

    int checks   = 0;
    int failures = 0;

    // Reference state
    int         m_pc;
    logic [7:0] m_word;
    bit         m_exec;
    int         m_fetched;

    always #5 clock = ~clock;

    assign rom_data = rom[pc];

    fetch_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .load_pc     (load_pc),
        .load_addr   (load_addr),
        .rom_data    (rom_data),
        .pc          (pc),
        .instr       (instr),
        .oprnd       (oprnd),
        .phase       (phase),
        .fetch_count (fetch_count)
    );

    function automatic logic [28:0] model_vec();
        logic [7:0] sat;
        sat = (m_fetched > 255) ? 8'hFF : 8'(m_fetched);
        return {12'(m_pc), m_word, m_exec, sat};
    endfunction

    logic [28:0] dut_vec;
    assign dut_vec = {pc, instr, oprnd, phase, fetch_count};

    task automatic model_reset();
        m_pc = 0; m_word = 8'h00; m_exec = 1'b0; m_fetched = 0;
    endtask

    // Drive one clock: inputs applied away from the edge, model advanced at the
    // edge, and control returned on the following falling edge for sampling.
    task automatic cycle(input logic r, input logic l, input logic [11:0] a);
        run = r; load_pc = l; load_addr = a;
        @(posedge clock);
        if (r) begin
            if (!m_exec) begin
                m_word    = rom[m_pc];
                m_pc      = (m_pc + 1) % 4096;
                m_fetched = m_fetched + 1;
                m_exec    = 1'b1;
            end else begin
                if (l) m_pc = int'(a);
                m_exec = 1'b0;
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; load_pc = 1'b0; load_addr = '0;
        rom[0] = 8'hA5;
        #4;
        checks++; if (pc !== 12'h000) begin failures++; $display("FAIL reset_pc got=%h exp=000", pc); end
        checks++; if (instr !== 4'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr); end
        checks++; if (oprnd !== 4'h0) begin failures++; $display("FAIL reset_oprnd got=%h exp=0", oprnd); end
        checks++; if (phase !== 1'b0) begin failures++; $display("FAIL reset_phase got=%b exp=0", phase); end
        checks++; if (fetch_count !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", fetch_count); end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential();
        rom[0] = 8'h3A; rom[1] = 8'h24;
        cycle(1, 0, 0);
        checks++; if ({instr, oprnd, pc, phase} !== {4'h3, 4'hA, 12'h001, 1'b1}) begin
            failures++; $display("FAIL seq_edge1 got=%h/%h/%h/%b exp=3/a/001/1", instr, oprnd, pc, phase);
        end
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        checks++; if ({instr, oprnd, pc, fetch_count} !== {4'h2, 4'h4, 12'h002, 8'h02}) begin
            failures++; $display("FAIL seq_edge3 got=%h/%h/%h/%h exp=2/4/002/02", instr, oprnd, pc, fetch_count);
        end
        checks++; if (dut_vec !== model_vec()) begin
            failures++; $display("FAIL seq_model got=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_jump();
        logic [7:0] w;
        w = 8'($urandom);
        rom[12'h0F0] = w;
        cycle(1, 1, 12'h0F0);  // in EXEC: jump taken
        checks++; if ({pc, phase} !== {12'h0F0, 1'b0}) begin
            failures++; $display("FAIL jump_pc got=%h/%b exp=0f0/0", pc, phase);
        end
        cycle(1, 0, 0);
        checks++; if ({instr, oprnd, pc} !== {w, 12'h0F1}) begin
            failures++; $display("FAIL jump_fetch got=%h%h/%h exp=%h/0f1", instr, oprnd, pc, w);
        end
        cycle(1, 0, 0);
        cycle(1, 1, 12'h555);  // in FETCH: jump ignored
        checks++; if ({pc, phase} !== {12'h0F2, 1'b1}) begin
            failures++; $display("FAIL jump_in_fetch got=%h/%b exp=0f2/1", pc, phase);
        end
        checks++; if (dut_vec !== model_vec()) begin
            failures++; $display("FAIL jump_model got=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_stall();
        logic [28:0] snap;
        snap = dut_vec;  // stage sits in EXEC here
        checks++; if (phase !== 1'b1) begin failures++; $display("FAIL stall_entry got=%b exp=1", phase); end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 12'($urandom));
            checks++; if (dut_vec !== model_vec()) begin
                failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        checks++; if (dut_vec !== snap) begin
            failures++; $display("FAIL stall_snapshot got=%h exp=%h", dut_vec, snap);
        end
        cycle(1, 0, 0);
        checks++; if ({phase, pc} !== {1'b0, snap[28:17]}) begin
            failures++; $display("FAIL stall_resume got=%b/%h exp=0/%h", phase, pc, snap[28:17]);
        end
    endtask

    task automatic test_wrap_saturate();
        cycle(1, 0, 0);
        cycle(1, 1, 12'hFFF);
        checks++; if (pc !== 12'hFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=fff", pc); end
        cycle(1, 0, 0);
        checks++; if ({pc, instr, oprnd} !== {12'h000, rom[12'hFFF]}) begin
            failures++; $display("FAIL wrap_pc got=%h/%h%h exp=000/%h", pc, instr, oprnd, rom[12'hFFF]);
        end
        // Randomized traffic with stalls and jumps, checked every cycle.
        for (int i = 0; i < 700; i++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), 12'($urandom));
            checks++; if (dut_vec !== model_vec()) begin
                failures++; $display("FAIL rand_cycle%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        for (int i = 0; i < 600; i++) cycle(1, 0, 0);
        checks++; if (fetch_count !== 8'hFF) begin
            failures++; $display("FAIL saturate got=%h exp=ff", fetch_count);
        end
        checks++; if (dut_vec !== model_vec()) begin
            failures++; $display("FAIL saturate_model got=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        if (!m_exec) cycle(1, 0, 0);
        checks++; if (phase !== 1'b1) begin failures++; $display("FAIL areset_entry got=%b exp=1", phase); end
        #2 reset = 1'b1;
        #1;
        checks++; if (dut_vec !== 29'd0) begin
            failures++; $display("FAIL areset_clear got=%h exp=0", dut_vec);
        end
        #1 reset = 1'b0;
        model_reset();
        w = 8'($urandom);
        rom[0] = w;
        cycle(1, 0, 0);
        checks++; if ({instr, oprnd, pc, phase, fetch_count} !== {w, 12'h001, 1'b1, 8'h01}) begin
            failures++; $display("FAIL areset_first_fetch got=%h%h/%h/%b/%h exp=%h/001/1/01",
                                 instr, oprnd, pc, phase, fetch_count, w);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        test_reset();
        test_sequential();
        test_jump();
        test_stall();
        test_wrap_saturate();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage placed directly upstream of the accumulator/ALU datapath (`operacion`).
- Drives the ROM address, latches the returned byte and splits it into opcode and operand.
  - instr[2:0] feeds the ALU `selector`.
  - oprnd feeds the ALU `in`.
- A two-phase FSM (FETCH/EXEC) paces the design, so every instruction takes exactly 2 clocks.
- Accepts jump requests from the decode/control logic during EXEC.

Parameters:
- ADDR_W, 12, width of program counter / ROM address
- DATA_W, 8, ROM word width; upper half is instr, lower half is oprnd (DATA_W must be even)
- CNT_W, 8, width of the fetched-instruction counter

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- run  input  1  stage advances only while 1; when 0 all registers hold
- load_pc  input  1  jump request, honoured only in EXEC
- load_addr  input  ADDR_W  jump target
- rom_data  input  DATA_W  combinational ROM read data for address pc
- pc  output  ADDR_W  current program counter / ROM address
- instr  output  DATA_W/2  latched opcode
- oprnd  output  DATA_W/2  latched operand
- phase  output  1  0 = FETCH, 1 = EXEC; downstream enables accumulator only in EXEC
- fetch_count  output  CNT_W  number of instructions fetched since reset, saturating

Behaviour:
- Reset (asynchronous, any time, including mid-instruction):
  - pc=0, instr=0, oprnd=0, phase=0 (FETCH), fetch_count=0.
  - Reset has priority over every other input.
- All updates occur on the rising clock edge, and only when run=1. With run=0, every register holds, including phase.
- FETCH state, run=1, one edge:
  - {instr,oprnd} <= rom_data.
  - pc <= pc+1.
  - fetch_count <= fetch_count+1, saturating at all-ones.
  - phase <= EXEC.
- EXEC state, run=1, one edge:
  - If load_pc=1, pc <= load_addr; otherwise pc holds (it already points to the next instruction).
  - instr/oprnd hold.
  - phase <= FETCH.
- load_pc during FETCH is ignored and does not affect the increment.
- Latency: rom_data sampled at edge N is visible on instr/oprnd after edge N. It stays stable for the whole EXEC cycle and the following FETCH cycle, until the next fetch edge.
- PC wrap-around: pc = 2^ADDR_W-1 increments to 0 with no flag.
- A jump to load_addr = current pc is legal and re-executes the same address (tight loop).
- fetch_count saturates and does not wrap.
- The FSM has exactly 2 states. No illegal states are possible; a 1-bit encoding is required.
- No combinational path from any input to any output, except through registers. rom_data is only sampled.

Decomposition:
- Shared package fetch_pkg:
  - PHASE_FETCH=1'b0, PHASE_EXEC=1'b1.
  - Default ADDR_W/DATA_W constants.
  - The instr/oprnd split positions.
- One natural sub-module, program_counter:
  - Inputs: clock, reset, enable, inc, load, load_addr. Output: pc.
  - Load has priority over inc.
- fetch_unit instantiates program_counter plus the phase FSM, fetch register and counter.

Test Plan:
- Reset check: assert reset=1 for 5 time units with ROM data 8'hA5 → pc=0, instr=0, oprnd=0, phase=0, fetch_count=0. Release reset.
- Sequential fetch: ROM[0]=8'h3A, ROM[1]=8'h24, run=1 → after edge 1 instr=3, oprnd=A, pc=1, phase=1. After edge 3 instr=2, oprnd=4, pc=2, fetch_count=2.
- Jump: load_pc=1, load_addr=12'h0F0 during EXEC → pc=0F0 after that edge, and the next fetch latches ROM[0F0]. load_pc=1 during FETCH → pc increments normally and the jump is ignored.
- Stall: drop run for 3 cycles in EXEC → pc, instr, oprnd, phase and fetch_count are unchanged. Raise run → resumes with phase 1→0.
- Wrap/saturate: preload pc=12'hFFF via jump and fetch → pc=000. Run 300 instructions → fetch_count=8'hFF.
- Async reset mid-EXEC: assert reset between edges → outputs clear immediately, without waiting for a clock edge. After release, the first edge fetches ROM[0].
